// File: rtl/stopwatch_if.sv
// Button, scale and display bundle between the pins/testbench and stopwatch_ctrl.
// master drives the raw buttons and scale; slave is the controller.
interface stopwatch_if;
    logic       start_btn;
    logic       clear_btn;
    logic       lap_btn;
    logic [7:0] scale_in;
    logic [3:0] seg_digit;
    logic       digit_sel;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       running;
    logic       tick;
    logic       wrap;
    logic       lap_active;

    modport master (
        output start_btn, clear_btn, lap_btn, scale_in,
        input  seg_digit, digit_sel, ones, tens, running, tick, wrap, lap_active
    );

    modport slave (
        input  start_btn, clear_btn, lap_btn, scale_in,
        output seg_digit, digit_sel, ones, tens, running, tick, wrap, lap_active
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Start/pause/clear stopwatch with 00-99 BCD count and time-shared seg7 digit scheduling.
// Optional lap-freeze display enabled by defining LAP_EN.
module stopwatch_ctrl #(
    parameter logic [23:0] MAX_COUNT       = 24'd10_000_000,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
    parameter logic [15:0] MUX_DIV         = 16'd10_000
) (
    input  logic        clk,
    input  logic        rst_n,
    stopwatch_if.slave  sw
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

`ifdef LAP_EN
    localparam int NBTN = 3;
`else
    localparam int NBTN = 2;
`endif

    logic [NBTN-1:0] btn_raw_s;
    logic [NBTN-1:0] sync1_r;
    logic [NBTN-1:0] sync2_r;
    logic [NBTN-1:0] deb_r;
    logic [NBTN-1:0] deb_d_r;
    logic [NBTN-1:0] press_s;
    logic [15:0]     deb_cnt_r [NBTN];

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        clear_cnt_s;
    logic        start_press_s;
    logic        clear_press_s;

    logic [23:0] compare_s;
    logic [23:0] presc_r;
    logic [23:0] presc_nxt_s;
    logic        tick_s;
    logic [3:0]  ones_r;
    logic [3:0]  tens_r;
    logic [3:0]  ones_nxt_s;
    logic [3:0]  tens_nxt_s;
    logic        wrap_s;
    logic        tick_r;
    logic        wrap_r;
    logic        running_r;

    logic [15:0] mux_cnt_r;
    logic        digit_sel_r;
    logic        sel_nxt_s;
    logic [3:0]  seg_digit_r;
    logic [3:0]  ones_shown_s;
    logic [3:0]  tens_shown_s;

    // Two-flop synchronizer plus consecutive-mismatch debounce for every button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
            deb_r   <= '0;
            deb_d_r <= '0;
            for (int i = 0; i < NBTN; i++) begin
                deb_cnt_r[i] <= 16'd0;
            end
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
            deb_d_r <= deb_r;
            for (int i = 0; i < NBTN; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (deb_cnt_r[i] == DEBOUNCE_CYCLES - 16'd1) begin
                        deb_r[i]     <= sync2_r[i];
                        deb_cnt_r[i] <= 16'd0;
                    end else begin
                        deb_cnt_r[i] <= deb_cnt_r[i] + 16'd1;
                    end
                end else begin
                    deb_cnt_r[i] <= 16'd0;
                end
            end
        end
    end

    assign press_s       = deb_r & ~deb_d_r;
    assign start_press_s = press_s[0];
    assign clear_press_s = press_s[1];

    // Next-state decode; clear only has an effect from PAUSE and beats a simultaneous start
    always_comb begin
        state_nxt_s = state_r;
        clear_cnt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_press_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (start_press_s) begin
                    state_nxt_s = ST_PAUSE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (clear_press_s) begin
                    state_nxt_s = ST_IDLE;
                    clear_cnt_s = 1'b1;
                end else if (start_press_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                clear_cnt_s = 1'b1;
            end
        endcase
    end

    assign compare_s = (sw.scale_in == 8'd0) ? MAX_COUNT : {6'b0, sw.scale_in, 10'b0};

    // Prescaler; a compare value below the current count lets it run on and wrap at 2^24
    always_comb begin
        presc_nxt_s = presc_r;
        tick_s      = 1'b0;
        if (clear_cnt_s) begin
            presc_nxt_s = 24'd0;
        end else if (state_r == ST_RUN) begin
            if (presc_r == compare_s) begin
                presc_nxt_s = 24'd0;
                tick_s      = 1'b1;
            end else begin
                presc_nxt_s = presc_r + 24'd1;
            end
        end else if (state_r == ST_IDLE) begin
            presc_nxt_s = 24'd0;
        end else begin
            presc_nxt_s = presc_r;
        end
    end

    // Two-digit BCD count with roll-over flag
    always_comb begin
        ones_nxt_s = ones_r;
        tens_nxt_s = tens_r;
        wrap_s     = 1'b0;
        if (clear_cnt_s) begin
            ones_nxt_s = 4'd0;
            tens_nxt_s = 4'd0;
        end else if (tick_s) begin
            if (ones_r == 4'd9) begin
                ones_nxt_s = 4'd0;
                if (tens_r == 4'd9) begin
                    tens_nxt_s = 4'd0;
                    wrap_s     = 1'b1;
                end else begin
                    tens_nxt_s = tens_r + 4'd1;
                end
            end else begin
                ones_nxt_s = ones_r + 4'd1;
            end
        end else begin
            ones_nxt_s = ones_r;
            tens_nxt_s = tens_r;
        end
    end

    // State, count and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            presc_r   <= 24'd0;
            ones_r    <= 4'd0;
            tens_r    <= 4'd0;
            tick_r    <= 1'b0;
            wrap_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            presc_r   <= presc_nxt_s;
            ones_r    <= ones_nxt_s;
            tens_r    <= tens_nxt_s;
            tick_r    <= tick_s;
            wrap_r    <= wrap_s;
            running_r <= (state_nxt_s == ST_RUN);
        end
    end

`ifdef LAP_EN
    logic       lap_press_s;
    logic       lap_active_r;
    logic [3:0] lap_ones_r;
    logic [3:0] lap_tens_r;

    assign btn_raw_s   = {sw.lap_btn, sw.clear_btn, sw.start_btn};
    assign lap_press_s = press_s[2];

    // Lap freeze toggles only while running and always drops when RUN is left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_active_r <= 1'b0;
            lap_ones_r   <= 4'd0;
            lap_tens_r   <= 4'd0;
        end else if (state_nxt_s != ST_RUN) begin
            lap_active_r <= 1'b0;
        end else if (lap_press_s && (state_r == ST_RUN)) begin
            if (lap_active_r) begin
                lap_active_r <= 1'b0;
            end else begin
                lap_active_r <= 1'b1;
                lap_ones_r   <= ones_r;
                lap_tens_r   <= tens_r;
            end
        end
    end

    assign ones_shown_s  = lap_active_r ? lap_ones_r : ones_r;
    assign tens_shown_s  = lap_active_r ? lap_tens_r : tens_r;
    assign sw.lap_active = lap_active_r;
`else
    assign btn_raw_s     = {sw.clear_btn, sw.start_btn};
    assign ones_shown_s  = ones_r;
    assign tens_shown_s  = tens_r;
    assign sw.lap_active = 1'b0;
`endif

    assign sel_nxt_s = (mux_cnt_r == MUX_DIV - 16'd1) ? ~digit_sel_r : digit_sel_r;

    // Digit scheduler; seg_digit is loaded from the same select value so the pair stays coherent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_cnt_r   <= 16'd0;
            digit_sel_r <= 1'b0;
            seg_digit_r <= 4'd0;
        end else begin
            if (mux_cnt_r == MUX_DIV - 16'd1) begin
                mux_cnt_r <= 16'd0;
            end else begin
                mux_cnt_r <= mux_cnt_r + 16'd1;
            end
            digit_sel_r <= sel_nxt_s;
            seg_digit_r <= sel_nxt_s ? tens_shown_s : ones_shown_s;
        end
    end

    assign sw.seg_digit = seg_digit_r;
    assign sw.digit_sel = digit_sel_r;
    assign sw.ones      = ones_r;
    assign sw.tens      = tens_r;
    assign sw.running   = running_r;
    assign sw.tick      = tick_r;
    assign sw.wrap      = wrap_r;
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencing controller for the seconds-counter/seven-segment datapath. It turns the free-running tick-and-digit counter into a start/pause/clear stopwatch driven by two debounced push-buttons, with a two-digit BCD count (00-99). It time-shares one seg7 decoder between the ones and tens digits by scheduling a digit-select strobe. It sits between the top-level pins (ui_in buttons and scale, uo_out/uio_out) and the existing seg7 decoder.

Parameters:
MAX_COUNT, 24'd10_000_000, prescaler compare value used when scale_in == 0 (10 MHz clock gives 1 s tick)
DEBOUNCE_CYCLES, 16'd50_000, consecutive stable cycles required to accept a button level change (must be >= 1)
MUX_DIV, 16'd10_000, clock cycles each digit is shown before digit_sel toggles (must be >= 1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start_btn  input  1  raw start/stop button, active high, asynchronous
clear_btn  input  1  raw clear button, active high, asynchronous
lap_btn  input  1  raw lap button; used only with LAP_EN
scale_in  input  8  prescaler override; 0 selects MAX_COUNT
seg_digit  output  4  BCD value routed to the shared seg7 decoder
digit_sel  output  1  0 = ones digit displayed, 1 = tens digit displayed
ones  output  4  live ones count (BCD)
tens  output  4  live tens count (BCD)
running  output  1  high while in RUN
tick  output  1  one-cycle pulse per count increment
wrap  output  1  one-cycle pulse when the count rolls 99 -> 00
lap_active  output  1  high while the display is frozen (LAP_EN only, else 0)

Behaviour:
- Reset (rst_n low, asynchronous): FSM = IDLE; prescaler, ones, tens, debounce state, mux counter = 0; all outputs = 0.
- Button path, per button: 2-FF synchronizer, then debounce. The debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free cycle resets the debounce counter.
- A rising edge of the debounced level produces a one-cycle press pulse. FSM and registers react on the cycle after the pulse.
- Compare value = scale_in == 0 ? MAX_COUNT : {6'b0, scale_in, 10'b0}, evaluated combinationally every cycle.
- Prescaler behaviour by state:
  - RUN: the prescaler counts 0..compare. When it equals compare, it reloads to 0 and tick pulses. The tick period is compare+1 cycles.
  - PAUSE: the prescaler holds.
  - IDLE: the prescaler is held at 0.
  - If compare drops below the current prescaler value, the prescaler continues up and wraps at 2^24 (24-bit arithmetic). This is not guarded.
- BCD counter: on tick, ones increments. ones 9 -> 0 increments tens. At 99, the next tick gives 00 with wrap high for that cycle.
- FSM states IDLE, RUN, PAUSE:
  - IDLE: start press -> RUN. Clear press -> stay in IDLE.
  - RUN: start press -> PAUSE. Clear press is ignored.
  - PAUSE: start press -> RUN, with the count and prescaler resumed, not reset. Clear press -> IDLE, with ones, tens and prescaler cleared.
  - Simultaneous start and clear press in PAUSE: clear wins, go to IDLE. In other states, start acts and clear is ignored.
- running = (state == RUN), registered.
- Display scheduler: the mux counter counts 0..MUX_DIV-1 in every state. At MUX_DIV-1, digit_sel toggles and the counter reloads to 0.
- seg_digit = digit_sel ? tens_shown : ones_shown. The shown values equal the live values unless lap_active is high.
- seg_digit and digit_sel are registered together, so they never disagree.

Optional Feature:
- LAP_EN defined:
  - In RUN, a lap_btn press (same debounce path) latches ones/tens into the shown registers and sets lap_active. Counting continues.
  - A second lap press clears lap_active, and the display tracks the live count again.
  - Leaving RUN (start or clear) also clears lap_active.
- LAP_EN undefined: lap_btn is ignored (no synchronizer logic), lap_active is tied to 0, and the shown values equal the live values.

Test Plan:
(All tests use MAX_COUNT=9, DEBOUNCE_CYCLES=4, MUX_DIV=3, scale_in=0.)
- Reset then idle 50 cycles -> ones=tens=0, running=0, tick never asserts, digit_sel toggles every 3 cycles.
- start_btn high for 10 cycles -> running rises 7 cycles after the edge (2 sync + 4 debounce + 1). tick then pulses every 10 cycles, and the count reaches 05 after 50 further cycles.
- start_btn 2-cycle glitch (< DEBOUNCE_CYCLES) -> no state change, running stays 0.
- RUN from 98, two ticks -> 99 then 00, with wrap high for exactly the cycle of the second increment.
- PAUSE at 37, press clear and start together -> IDLE, ones=tens=0, running=0. Next start press resumes from 00.
- LAP_EN: RUN at 12, press lap -> seg_digit shows 2/1 while ones advances to 15. Press lap again -> seg_digit tracks 5/1, lap_active=0.
